// File: rtl/rca_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package   : rca_pkg                                                      |
// | Purpose   : State encodings and nibble constants for the sequential     |
// |             ripple-carry adder.                                          |
// | Revision  : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package rca_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] RCA_IDLE = 2'b00;
    localparam logic [1:0] RCA_RUN  = 2'b01;
    localparam logic [1:0] RCA_DONE = 2'b10;

    // A single-nibble adder still needs a 1-bit index register.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage : rca_pkg
`default_nettype wire

// File: rtl/RCA_4bit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : RCA_4bit                                                     |
// | Purpose   : Purely combinational 4-bit ripple-carry adder.               |
// | Revision  : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module RCA_4bit
    import rca_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[NIBBLE_W];

endmodule : RCA_4bit
`default_nettype wire

// File: rtl/rca_seq_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : rca_seq_adder                                                |
// | Purpose   : WIDTH-bit adder that reuses one RCA_4bit, one nibble per     |
// |             clock LSB-first, with a registered carry between nibbles.    |
// | Revision  : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module rca_seq_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = idx_width(NIB);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_carry;
    logic                r_cout;

    logic                w_accept;
    logic                w_run;
    logic                w_last;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_rca_sum;
    logic                w_rca_cout;

    // A new operation may be accepted from IDLE or directly from DONE.
    assign w_accept = start && ((r_state == RCA_IDLE) || (r_state == RCA_DONE));
    assign w_run    = (r_state == RCA_RUN);
    assign w_last   = (r_idx == IDX_W'(NIB - 1));

    //--------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RCA_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------
    always_comb begin
        w_state_nxt = RCA_IDLE;
        case (r_state)
            RCA_IDLE: w_state_nxt = start  ? RCA_RUN  : RCA_IDLE;
            RCA_RUN:  w_state_nxt = w_last ? RCA_DONE : RCA_RUN;
            RCA_DONE: w_state_nxt = start  ? RCA_RUN  : RCA_IDLE;
            default:  w_state_nxt = RCA_IDLE;
        endcase
    end

    //--------------------------------------------------------------------
    // FSM: outputs (decoded from the registered state, so glitch-free)
    //--------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RCA_RUN:  busy = 1'b1;
            RCA_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------
    // Current nibble select for the shared adder
    //--------------------------------------------------------------------
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int i = 0; i < NIB; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_nib = r_a[i*NIBBLE_W +: NIBBLE_W];
                w_b_nib = r_b[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    RCA_4bit u_rca (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_rca_sum),
        .cout (w_rca_cout)
    );

    //--------------------------------------------------------------------
    // Operand, carry, index and carry-out registers
    //--------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_cout  <= 1'b0;
        end else if (w_run) begin
            r_carry <= w_rca_cout;
            if (w_last) begin
                r_cout <= w_rca_cout;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    //--------------------------------------------------------------------
    // Result nibbles: each slice owns its register, written on its step
    //--------------------------------------------------------------------
    for (genvar i = 0; i < NIB; i++) begin : g_sum
        logic [NIBBLE_W-1:0] r_nib;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_nib <= '0;
            end else if (w_accept) begin
                r_nib <= '0;
            end else if (w_run && (r_idx == IDX_W'(i))) begin
                r_nib <= w_rca_sum;
            end
        end

        assign sum[i*NIBBLE_W +: NIBBLE_W] = r_nib;
    end

    assign cout = r_cout;

endmodule : rca_seq_adder
`default_nettype wire
